// File: rtl/pt_axi4lite_arb2.sv
// Two-master to one-slave AXI4-Lite arbiter with round-robin grant per channel,
// registered downstream request slots and ID FIFOs that steer B/R back to the issuer.

module pt_axi4lite_arb2_idfifo #(
  parameter int DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      // push and pop together leave the level unchanged, even when full
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
endmodule

module pt_axi4lite_arb2 #(
  parameter  int AXI_ADDR_W  = 32,
  parameter  int DATA_W      = 64,
  parameter  int OUTSTANDING = 4,
  localparam int STRB_W      = DATA_W / 8,
  localparam int PROT_W      = 3,
  localparam int RESP_W      = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [1:0][AXI_ADDR_W-1:0]       i_m_awaddr,
  input  logic [1:0][PROT_W-1:0]           i_m_awprot,
  input  logic [1:0]                       i_m_awvalid,
  output logic [1:0]                       o_m_awready,
  input  logic [1:0][DATA_W-1:0]           i_m_wdata,
  input  logic [1:0][STRB_W-1:0]           i_m_wstrb,
  input  logic [1:0]                       i_m_wvalid,
  output logic [1:0]                       o_m_wready,
  output logic [1:0][RESP_W-1:0]           o_m_bresp,
  output logic [1:0]                       o_m_bvalid,
  input  logic [1:0]                       i_m_bready,
  input  logic [1:0][AXI_ADDR_W-1:0]       i_m_araddr,
  input  logic [1:0][PROT_W-1:0]           i_m_arprot,
  input  logic [1:0]                       i_m_arvalid,
  output logic [1:0]                       o_m_arready,
  output logic [1:0][DATA_W-1:0]           o_m_rdata,
  output logic [1:0][RESP_W-1:0]           o_m_rresp,
  output logic [1:0]                       o_m_rvalid,
  input  logic [1:0]                       i_m_rready,
  output logic [AXI_ADDR_W-1:0]            o_awaddr,
  output logic [PROT_W-1:0]                o_awprot,
  output logic                             o_awvalid,
  input  logic                             i_awready,
  output logic [DATA_W-1:0]                o_wdata,
  output logic [STRB_W-1:0]                o_wstrb,
  output logic                             o_wvalid,
  input  logic                             i_wready,
  input  logic [RESP_W-1:0]                i_bresp,
  input  logic                             i_bvalid,
  output logic                             o_bready,
  output logic [AXI_ADDR_W-1:0]            o_araddr,
  output logic [PROT_W-1:0]                o_arprot,
  output logic                             o_arvalid,
  input  logic                             i_arready,
  input  logic [DATA_W-1:0]                i_rdata,
  input  logic [RESP_W-1:0]                i_rresp,
  input  logic                             i_rvalid,
  output logic                             o_rready
);
  logic       w_ptr, r_ptr;
  logic [1:0] w_elig, r_elig;
  logic       w_idx, r_idx, w_gnt, r_gnt;
  logic       wf_head, wf_full, wf_empty, wf_pop;
  logic       rf_head, rf_full, rf_empty, rf_pop;

  // Write arbitration: AW and W of one master are always taken together
  assign w_elig = i_m_awvalid & i_m_wvalid;
  assign w_idx  = (&w_elig) ? w_ptr : w_elig[1];
  assign w_gnt  = i_rst_n && (|w_elig) && (!o_awvalid || i_awready) &&
                  (!o_wvalid || i_wready) && !wf_full;

  assign o_m_awready = w_gnt ? (w_idx ? 2'b10 : 2'b01) : 2'b00;
  assign o_m_wready  = o_m_awready;

  assign r_elig = i_m_arvalid;
  assign r_idx  = (&r_elig) ? r_ptr : r_elig[1];
  assign r_gnt  = i_rst_n && (|r_elig) && (!o_arvalid || i_arready) && !rf_full;

  assign o_m_arready = r_gnt ? (r_idx ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w_ptr     <= 1'b0;
      r_ptr     <= 1'b0;
      o_awvalid <= 1'b0;
      o_awaddr  <= '0;
      o_awprot  <= '0;
      o_wvalid  <= 1'b0;
      o_wdata   <= '0;
      o_wstrb   <= '0;
      o_arvalid <= 1'b0;
      o_araddr  <= '0;
      o_arprot  <= '0;
    end else begin
      if (w_gnt) begin
        w_ptr     <= ~w_idx;
        o_awvalid <= 1'b1;
        o_awaddr  <= i_m_awaddr[w_idx];
        o_awprot  <= i_m_awprot[w_idx];
        o_wvalid  <= 1'b1;
        o_wdata   <= i_m_wdata[w_idx];
        o_wstrb   <= i_m_wstrb[w_idx];
      end else begin
        // the two write slots drain independently
        if (i_awready) o_awvalid <= 1'b0;
        if (i_wready)  o_wvalid  <= 1'b0;
      end
      if (r_gnt) begin
        r_ptr     <= ~r_idx;
        o_arvalid <= 1'b1;
        o_araddr  <= i_m_araddr[r_idx];
        o_arprot  <= i_m_arprot[r_idx];
      end else if (i_arready) begin
        o_arvalid <= 1'b0;
      end
    end
  end

  pt_axi4lite_arb2_idfifo #(.DEPTH(OUTSTANDING)) u_wfifo (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .push(w_gnt), .din(w_idx), .pop(wf_pop),
    .head(wf_head), .full(wf_full), .empty(wf_empty)
  );

  pt_axi4lite_arb2_idfifo #(.DEPTH(OUTSTANDING)) u_rfifo (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .push(r_gnt), .din(r_idx), .pop(rf_pop),
    .head(rf_head), .full(rf_full), .empty(rf_empty)
  );

  // Responses with nothing outstanding are never accepted nor shown upstream
  assign o_bready   = !wf_empty && i_m_bready[wf_head];
  assign wf_pop     = i_bvalid && o_bready;
  assign o_m_bvalid = (!wf_empty && i_bvalid) ? (wf_head ? 2'b10 : 2'b01) : 2'b00;
  assign o_m_bresp  = wf_empty ? '0 : {2{i_bresp}};

  assign o_rready   = !rf_empty && i_m_rready[rf_head];
  assign rf_pop     = i_rvalid && o_rready;
  assign o_m_rvalid = (!rf_empty && i_rvalid) ? (rf_head ? 2'b10 : 2'b01) : 2'b00;
  assign o_m_rdata  = rf_empty ? '0 : {2{i_rdata}};
  assign o_m_rresp  = rf_empty ? '0 : {2{i_rresp}};
endmodule

// File: tb/tb_pt_axi4lite_arb2.sv
// Directed bench for pt_axi4lite_arb2: cycle-by-cycle vector table plus reset sequences.

module tb_pt_axi4lite_arb2;
  localparam int AW = 32, DW = 64, SW = DW / 8;

  logic                 i_clk = 1'b0, i_rst_n = 1'b0;
  logic [1:0][AW-1:0]   i_m_awaddr, i_m_araddr;
  logic [1:0][2:0]      i_m_awprot, i_m_arprot;
  logic [1:0]           i_m_awvalid, i_m_wvalid, i_m_bready, i_m_arvalid, i_m_rready;
  logic [1:0][DW-1:0]   i_m_wdata;
  logic [1:0][SW-1:0]   i_m_wstrb;
  logic [1:0]           o_m_awready, o_m_wready, o_m_bvalid, o_m_arready, o_m_rvalid;
  logic [1:0][1:0]      o_m_bresp, o_m_rresp;
  logic [1:0][DW-1:0]   o_m_rdata;
  logic [AW-1:0]        o_awaddr, o_araddr;
  logic [2:0]           o_awprot, o_arprot;
  logic                 o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready;
  logic                 i_awready, i_wready, i_bvalid, i_arready, i_rvalid;
  logic [DW-1:0]        o_wdata, i_rdata;
  logic [SW-1:0]        o_wstrb;
  logic [1:0]           i_bresp, i_rresp;

  pt_axi4lite_arb2 #(.AXI_ADDR_W(AW), .DATA_W(DW), .OUTSTANDING(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_m_awaddr(i_m_awaddr), .i_m_awprot(i_m_awprot), .i_m_awvalid(i_m_awvalid),
    .o_m_awready(o_m_awready), .i_m_wdata(i_m_wdata), .i_m_wstrb(i_m_wstrb),
    .i_m_wvalid(i_m_wvalid), .o_m_wready(o_m_wready), .o_m_bresp(o_m_bresp),
    .o_m_bvalid(o_m_bvalid), .i_m_bready(i_m_bready), .i_m_araddr(i_m_araddr),
    .i_m_arprot(i_m_arprot), .i_m_arvalid(i_m_arvalid), .o_m_arready(o_m_arready),
    .o_m_rdata(o_m_rdata), .o_m_rresp(o_m_rresp), .o_m_rvalid(o_m_rvalid),
    .i_m_rready(i_m_rready), .o_awaddr(o_awaddr), .o_awprot(o_awprot),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .i_bresp(i_bresp), .i_bvalid(i_bvalid),
    .o_bready(o_bready), .o_araddr(o_araddr), .o_arprot(o_arprot),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .i_rdata(i_rdata), .i_rresp(i_rresp),
    .i_rvalid(i_rvalid), .o_rready(o_rready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       nm;
    logic [1:0]  awv, wv, arv;
    logic        awr, wr, arr, bv;
    logic [1:0]  br, bry;
    logic        rv;
    logic [1:0]  rry;
    logic [1:0]  e_awrdy, e_wrdy, e_arrdy;
    logic        e_awv;
    logic [31:0] e_awaddr;
    logic        e_wv;
    logic [63:0] e_wdata;
    logic        e_arv;
    logic [31:0] e_araddr;
    logic [1:0]  e_bv;
    logic        e_bry;
    logic [1:0]  e_bresp1, e_rv;
    logic        e_rry;
  } vec_t;

  vec_t tbl[$];
  int checks = 0, errors = 0;

  task automatic add(input string nm, input logic [1:0] awv, wv, arv,
                     input logic awr, wr, arr, bv, input logic [1:0] br, bry,
                     input logic rv, input logic [1:0] rry,
                     input logic [1:0] e_awrdy, e_wrdy, e_arrdy,
                     input logic e_awv, input logic [31:0] e_awaddr,
                     input logic e_wv, input logic [63:0] e_wdata,
                     input logic e_arv, input logic [31:0] e_araddr,
                     input logic [1:0] e_bv, input logic e_bry, input logic [1:0] e_bresp1,
                     input logic [1:0] e_rv, input logic e_rry);
    vec_t v;
    v.nm = nm; v.awv = awv; v.wv = wv; v.arv = arv; v.awr = awr; v.wr = wr; v.arr = arr;
    v.bv = bv; v.br = br; v.bry = bry; v.rv = rv; v.rry = rry;
    v.e_awrdy = e_awrdy; v.e_wrdy = e_wrdy; v.e_arrdy = e_arrdy;
    v.e_awv = e_awv; v.e_awaddr = e_awaddr; v.e_wv = e_wv; v.e_wdata = e_wdata;
    v.e_arv = e_arv; v.e_araddr = e_araddr; v.e_bv = e_bv; v.e_bry = e_bry;
    v.e_bresp1 = e_bresp1; v.e_rv = e_rv; v.e_rry = e_rry;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] awv, wv, arv, input logic awr, wr, arr, bv,
                       input logic [1:0] br, bry, input logic rv, input logic [1:0] rry);
    i_m_awvalid = awv; i_m_wvalid = wv; i_m_arvalid = arv;
    i_awready = awr; i_wready = wr; i_arready = arr;
    i_bvalid = bv; i_bresp = br; i_m_bready = bry;
    i_rvalid = rv; i_m_rready = rry;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "/ctl"}, 64'({o_m_awready, o_m_wready, o_m_arready, o_m_bvalid, o_m_rvalid,
                           o_bready, o_rready, o_awvalid, o_wvalid, o_arvalid}), 64'd0);
    chk({nm, "/pay"}, 64'(|{o_awaddr, o_awprot, o_wdata, o_wstrb, o_araddr, o_arprot,
                            o_m_bresp, o_m_rdata, o_m_rresp}), 64'd0);
  endtask

  initial begin
    i_m_awaddr[0] = 32'h100; i_m_awaddr[1] = 32'h10;
    i_m_awprot[0] = 3'd0;    i_m_awprot[1] = 3'd5;
    i_m_wdata[0]  = 64'h1111; i_m_wdata[1] = 64'hAA55;
    i_m_wstrb[0]  = 8'hFF;   i_m_wstrb[1] = 8'h0F;
    i_m_araddr[0] = 32'h200; i_m_araddr[1] = 32'h300;
    i_m_arprot[0] = 3'd2;    i_m_arprot[1] = 3'd1;
    i_rresp = 2'd1; i_rdata = 64'hCAFE_0000_0000_0001;

    //   name          awv   wv    arv   awr wr arr bv br bry   rv rry | awrdy wrdy arrdy awv awaddr wv wdata arv araddr bv bry bresp1 rv rry
    add("wr1_req",     2'b10,2'b10,2'b00,1,1,0, 0,0,2'b00, 0,2'b00, 2'b10,2'b10,2'b00, 0,0,     0,0,      0,0,      2'b00,0,0, 2'b00,0);
    add("wr1_fwd",     2'b00,2'b00,2'b00,1,1,0, 0,0,2'b00, 0,2'b00, 2'b00,2'b00,2'b00, 1,'h10,  1,'hAA55, 0,0,      2'b00,0,0, 2'b00,0);
    add("wr1_b",       2'b00,2'b00,2'b00,1,1,0, 1,2,2'b10, 0,2'b00, 2'b00,2'b00,2'b00, 0,0,     0,0,      0,0,      2'b10,1,2, 2'b00,0);
    add("b_orphan",    2'b00,2'b00,2'b00,1,1,0, 1,2,2'b11, 0,2'b00, 2'b00,2'b00,2'b00, 0,0,     0,0,      0,0,      2'b00,0,0, 2'b00,0);
    add("lone_w",      2'b00,2'b01,2'b00,1,1,0, 0,0,2'b00, 0,2'b00, 2'b00,2'b00,2'b00, 0,0,     0,0,      0,0,      2'b00,0,0, 2'b00,0);
    add("w_plus_aw",   2'b01,2'b01,2'b00,1,1,0, 0,0,2'b00, 0,2'b00, 2'b01,2'b01,2'b00, 0,0,     0,0,      0,0,      2'b00,0,0, 2'b00,0);
    add("w0_fwd",      2'b00,2'b00,2'b00,1,1,0, 0,0,2'b00, 0,2'b00, 2'b00,2'b00,2'b00, 1,'h100, 1,'h1111, 0,0,      2'b00,0,0, 2'b00,0);
    add("w0_b",        2'b00,2'b00,2'b00,1,1,0, 1,0,2'b01, 0,2'b00, 2'b00,2'b00,2'b00, 0,0,     0,0,      0,0,      2'b01,1,0, 2'b00,0);
    add("split_gnt",   2'b11,2'b11,2'b00,1,0,0, 0,0,2'b00, 0,2'b00, 2'b10,2'b10,2'b00, 0,0,     0,0,      0,0,      2'b00,0,0, 2'b00,0);
    add("split_hold1", 2'b11,2'b11,2'b00,1,0,0, 0,0,2'b00, 0,2'b00, 2'b00,2'b00,2'b00, 1,'h10,  1,'hAA55, 0,0,      2'b00,0,0, 2'b00,0);
    add("split_hold2", 2'b11,2'b11,2'b00,1,0,0, 0,0,2'b00, 0,2'b00, 2'b00,2'b00,2'b00, 0,0,     1,'hAA55, 0,0,      2'b00,0,0, 2'b00,0);
    add("split_drain", 2'b11,2'b11,2'b00,1,1,0, 0,0,2'b00, 0,2'b00, 2'b01,2'b01,2'b00, 0,0,     1,'hAA55, 0,0,      2'b00,0,0, 2'b00,0);
    add("split_fwd",   2'b00,2'b00,2'b00,1,1,0, 0,0,2'b00, 0,2'b00, 2'b00,2'b00,2'b00, 1,'h100, 1,'h1111, 0,0,      2'b00,0,0, 2'b00,0);
    add("split_b1",    2'b00,2'b00,2'b00,1,1,0, 1,1,2'b11, 0,2'b00, 2'b00,2'b00,2'b00, 0,0,     0,0,      0,0,      2'b10,1,1, 2'b00,0);
    add("split_b0",    2'b00,2'b00,2'b00,1,1,0, 1,3,2'b01, 0,2'b00, 2'b00,2'b00,2'b00, 0,0,     0,0,      0,0,      2'b01,1,3, 2'b00,0);
    add("rr0",         2'b00,2'b00,2'b11,0,0,1, 0,0,2'b00, 0,2'b00, 2'b00,2'b00,2'b01, 0,0,     0,0,      0,0,      2'b00,0,0, 2'b00,0);
    add("rr1",         2'b00,2'b00,2'b11,0,0,1, 0,0,2'b00, 1,2'b11, 2'b00,2'b00,2'b10, 0,0,     0,0,      1,'h200,  2'b00,0,0, 2'b01,1);
    add("rr2",         2'b00,2'b00,2'b11,0,0,1, 0,0,2'b00, 1,2'b11, 2'b00,2'b00,2'b01, 0,0,     0,0,      1,'h300,  2'b00,0,0, 2'b10,1);
    add("rr3",         2'b00,2'b00,2'b11,0,0,1, 0,0,2'b00, 1,2'b11, 2'b00,2'b00,2'b10, 0,0,     0,0,      1,'h200,  2'b00,0,0, 2'b01,1);
    add("rr4",         2'b00,2'b00,2'b11,0,0,1, 0,0,2'b00, 1,2'b11, 2'b00,2'b00,2'b01, 0,0,     0,0,      1,'h300,  2'b00,0,0, 2'b10,1);
    add("rr5",         2'b00,2'b00,2'b11,0,0,1, 0,0,2'b00, 1,2'b11, 2'b00,2'b00,2'b10, 0,0,     0,0,      1,'h200,  2'b00,0,0, 2'b01,1);
    add("rr_tail",     2'b00,2'b00,2'b00,0,0,1, 0,0,2'b00, 1,2'b11, 2'b00,2'b00,2'b00, 0,0,     0,0,      1,'h300,  2'b00,0,0, 2'b10,1);
    add("bp_gnt",      2'b00,2'b00,2'b11,0,0,0, 0,0,2'b00, 0,2'b00, 2'b00,2'b00,2'b01, 0,0,     0,0,      0,0,      2'b00,0,0, 2'b00,0);
    add("bp_hold1",    2'b00,2'b00,2'b11,0,0,0, 0,0,2'b00, 0,2'b00, 2'b00,2'b00,2'b00, 0,0,     0,0,      1,'h200,  2'b00,0,0, 2'b00,0);
    add("bp_hold2",    2'b00,2'b00,2'b11,0,0,0, 0,0,2'b00, 0,2'b00, 2'b00,2'b00,2'b00, 0,0,     0,0,      1,'h200,  2'b00,0,0, 2'b00,0);
    add("bp_rel1",     2'b00,2'b00,2'b11,0,0,1, 0,0,2'b00, 0,2'b00, 2'b00,2'b00,2'b10, 0,0,     0,0,      1,'h200,  2'b00,0,0, 2'b00,0);
    add("bp_rel2",     2'b00,2'b00,2'b11,0,0,1, 0,0,2'b00, 0,2'b00, 2'b00,2'b00,2'b01, 0,0,     0,0,      1,'h300,  2'b00,0,0, 2'b00,0);
    add("bp_rel3",     2'b00,2'b00,2'b11,0,0,1, 0,0,2'b00, 0,2'b00, 2'b00,2'b00,2'b10, 0,0,     0,0,      1,'h200,  2'b00,0,0, 2'b00,0);
    add("bp_full1",    2'b00,2'b00,2'b11,0,0,1, 0,0,2'b00, 0,2'b00, 2'b00,2'b00,2'b00, 0,0,     0,0,      1,'h300,  2'b00,0,0, 2'b00,0);
    add("bp_full2",    2'b00,2'b00,2'b11,0,0,1, 0,0,2'b00, 0,2'b00, 2'b00,2'b00,2'b00, 0,0,     0,0,      0,0,      2'b00,0,0, 2'b00,0);
    add("bp_pop",      2'b00,2'b00,2'b11,0,0,1, 0,0,2'b00, 1,2'b11, 2'b00,2'b00,2'b00, 0,0,     0,0,      0,0,      2'b00,0,0, 2'b01,1);
    add("bp_regnt",    2'b00,2'b00,2'b11,0,0,1, 0,0,2'b00, 0,2'b00, 2'b00,2'b00,2'b01, 0,0,     0,0,      0,0,      2'b00,0,0, 2'b00,0);
    add("drain_r1",    2'b00,2'b00,2'b00,0,0,0, 0,0,2'b00, 1,2'b11, 2'b00,2'b00,2'b00, 0,0,     0,0,      1,'h200,  2'b00,0,0, 2'b10,1);
    add("drain_r0",    2'b00,2'b00,2'b00,0,0,0, 0,0,2'b00, 1,2'b11, 2'b00,2'b00,2'b00, 0,0,     0,0,      1,'h200,  2'b00,0,0, 2'b01,1);

    // Reset held with every input asserted: outputs must stay at reset values
    drive(2'b11, 2'b11, 2'b11, 1, 1, 1, 1, 2'd3, 2'b11, 1, 2'b11);
    #3 chk_all_zero("por");
    @(negedge i_clk);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'd0, 2'b00, 0, 2'b00);
    i_rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge i_clk);
      drive(tbl[i].awv, tbl[i].wv, tbl[i].arv, tbl[i].awr, tbl[i].wr, tbl[i].arr,
            tbl[i].bv, tbl[i].br, tbl[i].bry, tbl[i].rv, tbl[i].rry);
      i_rdata = {32'hCAFE_0000, 32'(i)};
      #1;
      chk({tbl[i].nm, "/rdy"}, 64'({o_m_awready, o_m_wready, o_m_arready}),
          64'({tbl[i].e_awrdy, tbl[i].e_wrdy, tbl[i].e_arrdy}));
      chk({tbl[i].nm, "/awv"}, 64'(o_awvalid), 64'(tbl[i].e_awv));
      if (tbl[i].e_awv) chk({tbl[i].nm, "/awaddr"}, 64'(o_awaddr), 64'(tbl[i].e_awaddr));
      chk({tbl[i].nm, "/wv"}, 64'(o_wvalid), 64'(tbl[i].e_wv));
      if (tbl[i].e_wv) chk({tbl[i].nm, "/wdata"}, o_wdata, tbl[i].e_wdata);
      chk({tbl[i].nm, "/arv"}, 64'(o_arvalid), 64'(tbl[i].e_arv));
      if (tbl[i].e_arv) chk({tbl[i].nm, "/araddr"}, 64'(o_araddr), 64'(tbl[i].e_araddr));
      chk({tbl[i].nm, "/b"}, 64'({o_m_bvalid, o_bready, o_m_bresp[1]}),
          64'({tbl[i].e_bv, tbl[i].e_bry, tbl[i].e_bresp1}));
      chk({tbl[i].nm, "/r"}, 64'({o_m_rvalid, o_rready}), 64'({tbl[i].e_rv, tbl[i].e_rry}));
      if (tbl[i].e_rv != 2'b00) begin
        chk({tbl[i].nm, "/rdata0"}, o_m_rdata[0], {32'hCAFE_0000, 32'(i)});
        chk({tbl[i].nm, "/rdata1"}, o_m_rdata[1], {32'hCAFE_0000, 32'(i)});
      end
    end

    // Mid-flight reset with two reads outstanding and the AR slot full
    @(negedge i_clk);
    drive(2'b00, 2'b00, 2'b11, 0, 0, 1, 0, 2'd0, 2'b00, 1, 2'b11);
    #2 i_rst_n = 1'b0;
    #1 chk_all_zero("mid_rst");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'd0, 2'b00, 1, 2'b11);
    #1;
    chk("post_rst/r", 64'({o_m_rvalid, o_rready}), 64'd0);
    chk("post_rst/arv", 64'(o_arvalid), 64'd0);
    @(negedge i_clk);
    drive(2'b00, 2'b00, 2'b11, 0, 0, 1, 0, 2'd0, 2'b00, 0, 2'b00);
    #1 chk("post_rst/ptr", 64'(o_m_arready), 64'(2'b01));
    @(negedge i_clk);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 2'd0, 2'b00, 0, 2'b00);
    #1 chk("post_rst/araddr", 64'({o_arvalid, o_araddr}), 64'({1'b1, 32'h200}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
